// File: rtl/square_sequencer.sv
// square_sequencer: queues square-draw requests in a 4-entry FIFO and sequences
// them to an 8x8 square drawer (LOAD -> 1-cycle strobe -> 66-cycle hold).
// Optional feature macro: SQSEQ_CLIP_EN. When it is defined, requests whose
// top-left corner would push the square off-screen are accepted, discarded
// and counted in drop_count.
module square_sequencer (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [8:0] req_colour,
    input  logic       req_erase,
    output logic       Plot_n,
    output logic       Black_n,
    output logic [7:0] X_out,
    output logic [6:0] Y_out,
    output logic [8:0] Colour_out,
    output logic       busy,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, HOLD} state_t;

    // 64 pixels plus the drawer's 2-cycle pipeline: HOLD spans counts 65..0
    localparam logic [6:0] HOLD_START = 7'd65;

    state_t      state, state_nxt;
    logic [6:0]  hold_cnt;
    logic        erase_q;

    // FIFO entry layout: {erase, colour, y, x}
    logic [24:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_full, fifo_empty;
    logic        push, pop, accept, clip_hit;
    logic [24:0] rd_entry;

    assign fifo_full  = (fifo_count == 3'd4);
    assign fifo_empty = (fifo_count == 3'd0);
    assign pop        = (state == LOAD);
    // A pop in LOAD frees a slot in the same cycle, so a full FIFO can still
    // take a push then; pop comes from registered state, so no loop via req_valid.
    assign req_ready  = ~fifo_full | pop;
    assign accept     = req_valid & req_ready;
    assign push       = accept & ~clip_hit;
    assign rd_entry   = fifo_mem[rd_ptr];

`ifdef SQSEQ_CLIP_EN
    // Off-screen squares are taken off the bus but never drawn
    assign clip_hit = (req_x > 8'd152) | (req_y > 7'd112);

    // Count discarded requests, saturating at 255
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            drop_count <= 8'd0;
        end else if (accept && clip_hit && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    assign clip_hit   = 1'b0;
    assign drop_count = 8'd0;
`endif

    // FIFO storage: contents need no reset, emptiness is tracked by fifo_count
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_erase, req_colour, req_y, req_x};
        end
    end

    // FIFO pointers and occupancy; 2-bit pointers wrap modulo 4 naturally
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = LOAD;
            LOAD:    state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    if (hold_cnt == 7'd0) state_nxt = fifo_empty ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Hold down-counter: loaded as HOLD is entered, runs to zero
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hold_cnt <= 7'd0;
        end else if (state == STROBE) begin
            hold_cnt <= HOLD_START;
        end else if (state == HOLD && hold_cnt != 7'd0) begin
            hold_cnt <= hold_cnt - 7'd1;
        end
    end

    // Capture the popped entry; erase squares are always drawn black
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            X_out      <= 8'd0;
            Y_out      <= 7'd0;
            Colour_out <= 9'd0;
            erase_q    <= 1'b0;
        end else if (pop) begin
            X_out      <= rd_entry[7:0];
            Y_out      <= rd_entry[14:8];
            Colour_out <= rd_entry[24] ? 9'd0 : rd_entry[23:15];
            erase_q    <= rd_entry[24];
        end
    end

    // FSM outputs: exactly one active-low strobe, only in STROBE
    always_comb begin
        Plot_n  = 1'b1;
        Black_n = 1'b1;
        if (state == STROBE) begin
            if (erase_q) Black_n = 1'b0;
            else         Plot_n  = 1'b0;
        end
        busy = (state != IDLE) | ~fifo_empty;
    end

endmodule

// File: tb/tb_square_sequencer.sv
// Directed testbench for square_sequencer: single draw, erase draw, queue fill
// with push/pop at full, asynchronous reset mid-square and clipping.
module tb_square_sequencer;

    logic       Clock;
    logic       Resetn;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [8:0] req_colour;
    logic       req_erase;
    logic       Plot_n;
    logic       Black_n;
    logic [7:0] X_out;
    logic [6:0] Y_out;
    logic [8:0] Colour_out;
    logic       busy;
    logic [7:0] drop_count;

    square_sequencer dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_erase  (req_erase),
        .Plot_n     (Plot_n),
        .Black_n    (Black_n),
        .X_out      (X_out),
        .Y_out      (Y_out),
        .Colour_out (Colour_out),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] c;
        logic       plot_n;
        logic       black_n;
    } strobe_t;

    strobe_t strobes[$];

    always @(posedge Clock) cyc <= cyc + 1;

    // Record every strobe cycle seen on the falling edge
    always @(negedge Clock) begin
        if (!Plot_n || !Black_n) begin
            strobes.push_back('{cyc, X_out, Y_out, Colour_out, Plot_n, Black_n});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [7:0] x, input logic [6:0] y,
                           input logic [8:0] c, input logic e);
        req_valid  = v;
        req_x      = x;
        req_y      = y;
        req_colour = c;
        req_erase  = e;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (Plot_n && Black_n && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Walk the 66 HOLD cycles after a strobe, then confirm the sequencer idles
    task automatic hold_check(input string tag, input logic [7:0] x, input logic [6:0] y,
                              input logic [8:0] c);
        int bad = 0;
        for (int i = 1; i <= 66; i++) begin
            tick();
            if (X_out !== x || Y_out !== y || Colour_out !== c) bad++;
            if (!Plot_n || !Black_n || !busy) bad++;
        end
        check_val({tag, "_hold"}, bad, 0);
        tick();
        check_val({tag, "_idle_busy"}, busy, 0);
    endtask

    int n;

    initial begin
        Resetn = 1'b0;
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        repeat (2) tick();

        // Reset values
        check_val("rst_ready", req_ready, 1);
        check_val("rst_plot", Plot_n, 1);
        check_val("rst_black", Black_n, 1);
        check_val("rst_xyc", {X_out, Y_out, Colour_out}, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_drop", drop_count, 0);
        Resetn = 1'b1;
        repeat (2) tick();

        // Single plot request
        set_req(1'b1, 8'd10, 7'd20, 9'h1C0, 1'b0);
        check_val("t1_ready", req_ready, 1);
        tick();
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        check_val("t1_busy_queued", busy, 1);
        wait_strobe(n);
        check_val("t1_latency", n, 2);
        check_val("t1_plot", Plot_n, 0);
        check_val("t1_black", Black_n, 1);
        check_val("t1_x", X_out, 10);
        check_val("t1_y", Y_out, 20);
        check_val("t1_c", Colour_out, 9'h1C0);
        hold_check("t1", 8'd10, 7'd20, 9'h1C0);

        // Erase request: black strobe, colour forced to zero
        set_req(1'b1, 8'd3, 7'd4, 9'h1FF, 1'b1);
        tick();
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        wait_strobe(n);
        check_val("t2_latency", n, 2);
        check_val("t2_black", Black_n, 0);
        check_val("t2_plot", Plot_n, 1);
        check_val("t2_c", Colour_out, 0);
        check_val("t2_x", X_out, 3);
        hold_check("t2", 8'd3, 7'd4, 9'd0);

        // Five back-to-back requests, then a sixth against a full FIFO
        strobes.delete();
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 8'(30 + i), 7'(i), 9'(i * 7), (i == 3));
            check_val($sformatf("t3_ready%0d", i), req_ready, 1);
            tick();
        end
        set_req(1'b1, 8'd35, 7'd5, 9'd35, 1'b0);
        check_val("t3_full_ready", req_ready, 0);
        n = 0;
        while (!req_ready && n < 300) begin
            tick();
            n++;
        end
        check_val("t3_ready_in_load", req_ready, 1);
        tick();
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        check_val("t3_still_full", req_ready, 0);
        n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
        check_val("t3_drained", busy, 0);
        check_val("t3_count", strobes.size(), 6);
        for (int k = 0; k < 6 && k < strobes.size(); k++) begin
            check_val($sformatf("t3_x%0d", k), strobes[k].x, 30 + k);
            check_val($sformatf("t3_y%0d", k), strobes[k].y, k);
            check_val($sformatf("t3_c%0d", k), strobes[k].c, (k == 3) ? 0 : k * 7);
            check_val($sformatf("t3_kind%0d", k), {strobes[k].plot_n, strobes[k].black_n},
                      (k == 3) ? 2'b10 : 2'b01);
            if (k > 0) check_val($sformatf("t3_gap%0d", k), strobes[k].cyc - strobes[k-1].cyc, 68);
        end

        // Asynchronous reset 30 cycles into HOLD with two entries queued
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 8'(60 + i), 7'(10 + i), 9'h0AA, 1'b0);
            tick();
        end
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        wait_strobe(n);
        check_val("t4_strobe", Plot_n, 0);
        repeat (30) tick();
        check_val("t4_busy_before", busy, 1);
        #2 Resetn = 1'b0;
        #1;
        check_val("t4_rst_xyc", {X_out, Y_out, Colour_out}, 0);
        check_val("t4_rst_strobes", {Plot_n, Black_n}, 2'b11);
        check_val("t4_rst_busy", busy, 0);
        check_val("t4_rst_ready", req_ready, 1);
        tick();
        tick();
        Resetn = 1'b1;
        strobes.delete();
        repeat (150) tick();
        check_val("t4_no_strobes", strobes.size(), 0);
        check_val("t4_idle", busy, 0);

`ifdef SQSEQ_CLIP_EN
        // Clipped request is accepted and counted, never drawn
        set_req(1'b1, 8'd153, 7'd0, 9'h111, 1'b0);
        check_val("t5_clip_ready", req_ready, 1);
        tick();
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        repeat (10) tick();
        check_val("t5_clip_nostrobe", strobes.size(), 0);
        check_val("t5_drop1", drop_count, 1);
        check_val("t5_clip_idle", busy, 0);
        set_req(1'b1, 8'd152, 7'd112, 9'h007, 1'b0);
        tick();
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        wait_strobe(n);
        check_val("t5_edge_latency", n, 2);
        check_val("t5_edge_x", X_out, 152);
        check_val("t5_edge_y", Y_out, 112);
        check_val("t5_drop_kept", drop_count, 1);
`else
        // Without clipping an off-screen request is drawn and nothing is dropped
        set_req(1'b1, 8'd153, 7'd119, 9'h111, 1'b0);
        tick();
        set_req(1'b0, 8'd0, 7'd0, 9'd0, 1'b0);
        wait_strobe(n);
        check_val("t5_noclip_latency", n, 2);
        check_val("t5_noclip_x", X_out, 153);
        check_val("t5_drop_zero", drop_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/square_sequencer.md
SQUARE_SEQUENCER -- requirements
Module: square_sequencer

Interface
REQ-001: Clock  input  1  system clock; all state changes on rising edge.
REQ-002: Resetn  input  1  asynchronous, active-low reset.
REQ-003: req_valid  input  1  draw request present this cycle.
REQ-004: req_ready  output  1  sequencer accepts a request this cycle; transfer occurs when req_valid & req_ready.
REQ-005: req_x  input  8  square top-left X, 0..159.
REQ-006: req_y  input  7  square top-left Y, 0..119.
REQ-007: req_colour  input  9  square colour (3:3:3).
REQ-008: req_erase  input  1  1 = draw the square black.
REQ-009: Plot_n  output  1  active-low start strobe to the square drawer (plot command).
REQ-010: Black_n  output  1  active-low erase strobe to the square drawer.
REQ-011: X_out  output  8  held X for the square being drawn.
REQ-012: Y_out  output  7  held Y for the square being drawn.
REQ-013: Colour_out  output  9  held colour for the square being drawn.
REQ-014: busy  output  1  high while a square is being issued/drawn or the queue is non-empty.
REQ-015: drop_count  output  8  number of requests discarded by clipping (0 when clipping is compiled out).

Function
REQ-016: Requests SHALL enter a 4-entry FIFO of {x, y, colour, erase}; req_ready = FIFO not full.
REQ-017: Simultaneous push and pop with the FIFO full SHALL still accept the push; FIFO pointers SHALL wrap modulo 4.
REQ-018: FSM states: IDLE, LOAD, STROBE, HOLD.
REQ-019: IDLE -> LOAD when FIFO non-empty; LOAD pops one entry into the X_out/Y_out/Colour_out registers (1 cycle).
REQ-020: STROBE lasts exactly 1 cycle: Plot_n = 0 if entry erase = 0, else Black_n = 0; never both low.
REQ-021: HOLD SHALL keep X_out/Y_out/Colour_out stable for exactly 66 cycles (64-pixel 8x8 square plus 2-cycle drawer pipeline), counted by a 7-bit down-counter loaded with 65 on entry.
REQ-022: HOLD -> LOAD when counter reaches 0 and FIFO non-empty, else HOLD -> IDLE; back-to-back squares therefore start every 68 cycles.
REQ-023: Plot_n and Black_n SHALL be 1 in every state except STROBE.
REQ-024: For erase entries Colour_out SHALL be 9'b0 regardless of stored colour.
REQ-025: busy = (state != IDLE) | FIFO non-empty.
REQ-026: Requests arriving during LOAD/STROBE/HOLD SHALL queue without disturbing the square in progress.

Reset
REQ-027: Resetn low SHALL immediately force: state IDLE, FIFO empty, req_ready 1, Plot_n 1, Black_n 1, X_out 0, Y_out 0, Colour_out 0, busy 0, drop_count 0, hold counter 0.
REQ-028: Reset mid-square SHALL abandon the square and discard all queued entries; no strobe is issued in the first cycle after release.

Configuration
REQ-029: Macro SQSEQ_CLIP_EN: when defined, a request with req_x > 152 or req_y > 112 SHALL be accepted (req_ready honoured) but not queued, and drop_count SHALL increment, saturating at 255.
REQ-030: Without SQSEQ_CLIP_EN all accepted requests SHALL be queued unchanged and drop_count SHALL be constant 0.

Verification
REQ-031: Reset release, one request x=10 y=20 colour=9'h1C0 erase=0 -> Plot_n low for 1 cycle 2 cycles after acceptance, X_out=10/Y_out=20/Colour_out=9'h1C0 stable 66 cycles, then busy=0.
REQ-032: Request erase=1 colour=9'h1FF -> Black_n low 1 cycle, Plot_n stays 1, Colour_out=0.
REQ-033: Five requests on consecutive cycles while IDLE -> req_ready low on the 6th cycle only if FIFO full; all five strobes emitted 68 cycles apart in order.
REQ-034: Resetn pulsed low 30 cycles into HOLD with 2 entries queued -> all outputs at reset values asynchronously; no further strobes after release.
REQ-035: With SQSEQ_CLIP_EN, request x=153 y=0 -> no strobe, drop_count 0->1; request x=152 y=112 -> drawn normally.
REQ-036: Push and pop in the same cycle with FIFO full -> occupancy stays 4, no entry lost or duplicated.
